// File: rtl/imm_target_unit_pkg.sv
// Shared definitions for the immediate/target unit: op encodings, legal
// datapath widths and the control-transfer classifier.
package imm_target_unit_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_LUI   = 3'b100,
        IMM_AUIPC = 3'b101,
        IMM_JALR  = 3'b110,
        IMM_RSV   = 3'b111
    } imm_op_e;

    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;

    // Ops whose target is a jump/branch destination and so must be aligned.
    function automatic logic is_ctrl_xfer(input imm_op_e op);
        return op inside {IMM_B, IMM_J, IMM_JALR};
    endfunction

endpackage

// File: rtl/imm_target_unit_if.sv
// Request/result handshake bundle; master drives requests, slave is the unit.
interface imm_target_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_target;
    logic             out_misalign;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_inst, in_pc, in_rs1, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_misalign, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_inst, in_pc, in_rs1, in_tag, flush, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_misalign, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_target_unit_imm_decode.sv
// Combinational immediate extraction for every instruction format, sign
// extended from inst[31] to XLEN; the reserved op yields zero.
module imm_decode
    import imm_target_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  imm_op_e          op,
    input  logic [31:0]      inst,
    output logic [XLEN-1:0]  imm
);
    logic signed [31:0] imm32;
    logic               unused_opcode;

    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^inst[6:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        imm32 = '0;
        case (op)
            IMM_I, IMM_JALR:    imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:              imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:              imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                         inst[11:8], 1'b0};
            IMM_J:              imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                         inst[30:21], 1'b0};
            IMM_LUI, IMM_AUIPC: imm32 = {inst[31:12], 12'h000};
            default:            imm32 = '0;
        endcase
        imm = XLEN'(imm32);
    end

endmodule

// File: rtl/imm_target_unit.sv
// Immediate and target-address unit: decode, optional operand stage, then a
// registered result stage with valid/ready flow control and flush.
module imm_target_unit
    import imm_target_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STAGES      = 1,
    parameter int CHECK_ALIGN = 1,
    parameter int TAG_W       = 5
) (
    input logic                clk,
    input logic                rst_n,
    imm_target_unit_if.slave   bus
);
    if ((XLEN != XLEN_RV32) && (XLEN != XLEN_RV64)) begin : g_bad_xlen
        $error("imm_target_unit: XLEN must be 32 or 64");
    end
    if ((STAGES != 1) && (STAGES != 2)) begin : g_bad_stages
        $error("imm_target_unit: STAGES must be 1 or 2");
    end

    logic [XLEN-1:0]  dec_imm;
    imm_op_e          calc_op;
    logic [XLEN-1:0]  calc_imm, calc_pc, calc_rs1;
    logic [TAG_W-1:0] calc_tag;
    logic             calc_valid;
    logic [XLEN-1:0]  rel_sum, jalr_sum, calc_target;
    logic             calc_misalign, calc_illegal;

    logic             out_valid_q, out_misalign_q, out_illegal_q, out_load;
    logic [XLEN-1:0]  out_imm_q, out_target_q;
    logic [TAG_W-1:0] out_tag_q;

    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .op   (imm_op_e'(bus.in_op)),
        .inst (bus.in_inst),
        .imm  (dec_imm)
    );

    // The result stage can take new data when empty or being drained now.
    assign out_load = !out_valid_q || bus.out_ready;

    if (STAGES == 2) begin : g_two_stage
        logic             s1_valid;
        imm_op_e          s1_op;
        logic [XLEN-1:0]  s1_imm, s1_pc, s1_rs1;
        logic [TAG_W-1:0] s1_tag;

        assign bus.in_ready = !s1_valid || out_load;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_op    <= IMM_I;
                s1_imm   <= '0;
                s1_pc    <= '0;
                s1_rs1   <= '0;
                s1_tag   <= '0;
            end else begin
                // NOTE: registered state uses <= so every flop samples the
                // pre-edge values regardless of statement order.
                if (bus.flush)         s1_valid <= 1'b0;
                else if (bus.in_ready) s1_valid <= bus.in_valid;
                if (bus.in_valid && bus.in_ready) begin
                    s1_op  <= imm_op_e'(bus.in_op);
                    s1_imm <= dec_imm;
                    s1_pc  <= bus.in_pc;
                    s1_rs1 <= bus.in_rs1;
                    s1_tag <= bus.in_tag;
                end
            end
        end

        assign calc_valid = s1_valid;
        assign calc_op    = s1_op;
        assign calc_imm   = s1_imm;
        assign calc_pc    = s1_pc;
        assign calc_rs1   = s1_rs1;
        assign calc_tag   = s1_tag;
    end else begin : g_one_stage
        assign bus.in_ready = out_load;
        assign calc_valid   = bus.in_valid;
        assign calc_op      = imm_op_e'(bus.in_op);
        assign calc_imm     = dec_imm;
        assign calc_pc      = bus.in_pc;
        assign calc_rs1     = bus.in_rs1;
        assign calc_tag     = bus.in_tag;
    end

    always_comb begin
        rel_sum      = calc_pc + calc_imm;
        jalr_sum     = calc_rs1 + calc_imm;
        calc_target  = calc_imm;
        calc_illegal = 1'b0;
        case (calc_op)
            IMM_B, IMM_J, IMM_AUIPC: calc_target = rel_sum;
            IMM_JALR:                calc_target = jalr_sum & ~XLEN'(1);
            IMM_RSV: begin
                calc_target  = '0;
                calc_illegal = 1'b1;
            end
            default:                 calc_target = calc_imm;
        endcase
        calc_misalign = (CHECK_ALIGN != 0) && is_ctrl_xfer(calc_op) && calc_target[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_target_q   <= '0;
            out_misalign_q <= 1'b0;
            out_illegal_q  <= 1'b0;
            out_tag_q      <= '0;
        end else begin
            if (bus.flush)     out_valid_q <= 1'b0;
            else if (out_load) out_valid_q <= calc_valid;
            // Data only moves on a real transfer, so a stalled result holds.
            if (out_load && calc_valid) begin
                out_imm_q      <= calc_imm;
                out_target_q   <= calc_target;
                out_misalign_q <= calc_misalign;
                out_illegal_q  <= calc_illegal;
                out_tag_q      <= calc_tag;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_imm      = out_imm_q;
    assign bus.out_target   = out_target_q;
    assign bus.out_misalign = out_misalign_q;
    assign bus.out_illegal  = out_illegal_q;
    assign bus.out_tag      = out_tag_q;

endmodule

// File: tb/tb_imm_target_unit.sv
// Directed bench for imm_target_unit: four configurations share one stimulus
// stream; each scenario checks the instance it targets.
module tb_imm_target_unit;
    import imm_target_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, out_ready, flush;
    logic [2:0]  in_op;
    logic [31:0] in_inst;
    logic [63:0] in_pc, in_rs1;
    logic [4:0]  in_tag;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [4:0]  tag;
        logic [31:0] target;
    } vec_t;

    vec_t vq [4];

    always #5 clk = ~clk;

    imm_target_unit_if #(.XLEN(32), .TAG_W(5)) if_a ();
    imm_target_unit_if #(.XLEN(32), .TAG_W(5)) if_b ();
    imm_target_unit_if #(.XLEN(64), .TAG_W(5)) if_c ();
    imm_target_unit_if #(.XLEN(32), .TAG_W(5)) if_d ();

    assign if_a.in_valid = in_valid;  assign if_a.in_op = in_op;  assign if_a.in_inst = in_inst;
    assign if_a.in_pc = in_pc[31:0];  assign if_a.in_rs1 = in_rs1[31:0];  assign if_a.in_tag = in_tag;
    assign if_a.flush = flush;        assign if_a.out_ready = out_ready;
    assign if_b.in_valid = in_valid;  assign if_b.in_op = in_op;  assign if_b.in_inst = in_inst;
    assign if_b.in_pc = in_pc[31:0];  assign if_b.in_rs1 = in_rs1[31:0];  assign if_b.in_tag = in_tag;
    assign if_b.flush = flush;        assign if_b.out_ready = out_ready;
    assign if_c.in_valid = in_valid;  assign if_c.in_op = in_op;  assign if_c.in_inst = in_inst;
    assign if_c.in_pc = in_pc;        assign if_c.in_rs1 = in_rs1;  assign if_c.in_tag = in_tag;
    assign if_c.flush = flush;        assign if_c.out_ready = out_ready;
    assign if_d.in_valid = in_valid;  assign if_d.in_op = in_op;  assign if_d.in_inst = in_inst;
    assign if_d.in_pc = in_pc[31:0];  assign if_d.in_rs1 = in_rs1[31:0];  assign if_d.in_tag = in_tag;
    assign if_d.flush = flush;        assign if_d.out_ready = out_ready;

    imm_target_unit #(.XLEN(32), .STAGES(1), .CHECK_ALIGN(1), .TAG_W(5))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    imm_target_unit #(.XLEN(32), .STAGES(2), .CHECK_ALIGN(1), .TAG_W(5))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    imm_target_unit #(.XLEN(64), .STAGES(1), .CHECK_ALIGN(1), .TAG_W(5))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    imm_target_unit #(.XLEN(32), .STAGES(1), .CHECK_ALIGN(0), .TAG_W(5))
        dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_op    = v.op;
        in_inst  = v.inst;
        in_pc    = v.pc;
        in_rs1   = v.rs1;
        in_tag   = v.tag;
    endtask

    // One request, accepted at the next edge; results sampled 1 time unit later.
    task automatic send1(input logic [2:0] op, input logic [31:0] inst,
                         input logic [63:0] pc, input logic [63:0] rs1, input logic [4:0] tag);
        vec_t v;
        v = '{op: op, inst: inst, pc: pc, rs1: rs1, tag: tag, target: 32'h0};
        out_ready = 1'b1;
        flush     = 1'b0;
        drive(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic accepted, consumed;
        int   acc, got;

        vq[0] = '{op: IMM_LUI,   inst: 32'h123450B7, pc: 64'h0,    rs1: 64'h0,    tag: 5'd1, target: 32'h12345000};
        vq[1] = '{op: IMM_B,     inst: 32'hFE000EE3, pc: 64'h100,  rs1: 64'h0,    tag: 5'd2, target: 32'h000000FC};
        vq[2] = '{op: IMM_JALR,  inst: 32'h00008067, pc: 64'h0,    rs1: 64'h1003, tag: 5'd3, target: 32'h00001002};
        vq[3] = '{op: IMM_AUIPC, inst: 32'h00001017, pc: 64'h2000, rs1: 64'h0,    tag: 5'd4, target: 32'h00003000};

        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_op = 3'b000; in_inst = '0; in_pc = '0; in_rs1 = '0; in_tag = '0;

        // Reset state
        #12;
        check("rst_valid_a",  64'(if_a.out_valid), 64'd0);
        check("rst_target_c", if_c.out_target, 64'd0);
        check("rst_imm_c",    if_c.out_imm, 64'd0);
        check("rst_tag_a",    64'(if_a.out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready_a", 64'(if_a.in_ready), 64'd1);
        check("post_rst_ready_b", 64'(if_b.in_ready), 64'd1);

        // Format and target vectors, latency 1 on the single-stage units
        send1(IMM_B, 32'hFE000EE3, 64'h100, 64'h0, 5'd1);
        check("b_valid",    64'(if_a.out_valid), 64'd1);
        check("b_imm",      64'(if_a.out_imm), 64'hFFFF_FFFC);
        check("b_target",   64'(if_a.out_target), 64'h0000_00FC);
        check("b_misalign", 64'(if_a.out_misalign), 64'd0);
        check("b_tag",      64'(if_a.out_tag), 64'd1);
        check("b_imm64",    if_c.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        send1(IMM_J, 32'h0020006F, 64'h0, 64'h0, 5'd2);
        check("j_target",      64'(if_a.out_target), 64'h2);
        check("j_misalign",    64'(if_a.out_misalign), 64'd1);
        check("j_misalign_c",  64'(if_c.out_misalign), 64'd1);
        check("j_noalign_mis", 64'(if_d.out_misalign), 64'd0);
        check("j_noalign_tgt", 64'(if_d.out_target), 64'h2);

        send1(IMM_JALR, 32'h00008067, 64'h0, 64'h1003, 5'd3);
        check("jalr_target",   64'(if_a.out_target), 64'h1002);
        check("jalr_misalign", 64'(if_a.out_misalign), 64'd1);

        send1(IMM_LUI, 32'h123450B7, 64'h0, 64'h0, 5'd4);
        check("lui_imm",      64'(if_a.out_imm), 64'h1234_5000);
        check("lui_target",   64'(if_a.out_target), 64'h1234_5000);
        check("lui_illegal",  64'(if_a.out_illegal), 64'd0);

        send1(IMM_RSV, 32'hFFFFFFFF, 64'h40, 64'h40, 5'd5);
        check("rsv_illegal",  64'(if_a.out_illegal), 64'd1);
        check("rsv_target",   64'(if_a.out_target), 64'd0);
        check("rsv_imm",      64'(if_a.out_imm), 64'd0);
        check("rsv_target_c", if_c.out_target, 64'd0);
        check("rsv_misalign", 64'(if_a.out_misalign), 64'd0);

        send1(IMM_I, 32'hFFF00093, 64'h0, 64'h0, 5'd6);
        check("i_imm",     64'(if_a.out_imm), 64'hFFFF_FFFF);
        check("i_imm64",   if_c.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("i_illegal", 64'(if_a.out_illegal), 64'd0);

        send1(IMM_S, 32'h00000123, 64'h0, 64'h0, 5'd7);
        check("s_target",   64'(if_a.out_target), 64'h2);
        check("s_misalign", 64'(if_a.out_misalign), 64'd0);

        send1(IMM_AUIPC, 32'h80000017, 64'h1000, 64'h0, 5'd8);
        check("auipc_target64", if_c.out_target, 64'hFFFF_FFFF_8000_1000);
        check("auipc_target32", 64'(if_a.out_target), 64'h8000_1000);

        send1(IMM_AUIPC, 32'h00001017, 64'hFFFF_F000, 64'h0, 5'd9);
        check("wrap_target32", 64'(if_a.out_target), 64'h0);
        check("wrap_target64", if_c.out_target, 64'h1_0000_0000);

        repeat (3) @(posedge clk);
        #1;
        check("drained_b", 64'(if_b.out_valid), 64'd0);

        // Two-stage back-pressure: stall the output while four requests stream in
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (acc < 4) drive(vq[acc]);
            else         in_valid = 1'b0;
            #1;
            if (cyc == 4) begin
                check("stall_ready_b", 64'(if_b.in_ready), 64'd0);
                check("stall_accepts", 64'(acc), 64'd2);
            end
            if (if_b.out_valid) begin
                if (got < 4) begin
                    check($sformatf("pipe_target%0d", got), 64'(if_b.out_target), 64'(vq[got].target));
                    check($sformatf("pipe_tag%0d", got),    64'(if_b.out_tag),    64'(vq[got].tag));
                end else begin
                    check("pipe_extra_result", 64'(if_b.out_valid), 64'd0);
                end
            end
            accepted = in_valid && if_b.in_ready;
            consumed = if_b.out_valid && out_ready;
            @(posedge clk); #1;
            if (accepted) acc++;
            if (consumed) got++;
        end
        in_valid = 1'b0;
        check("pipe_delivered", 64'(got), 64'd4);

        // Flush with two entries in flight and a new request presented
        out_ready = 1'b0;
        drive(vq[0]);
        @(posedge clk); #1;
        drive(vq[1]);
        @(posedge clk); #1;
        check("pre_flush_valid_b", 64'(if_b.out_valid), 64'd1);
        drive(vq[2]);
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid_b", 64'(if_b.out_valid), 64'd0);
        check("flush_valid_a", 64'(if_a.out_valid), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("no_stale_b%0d", k), 64'(if_b.out_valid), 64'd0);
        end

        // Flush wins over an accept the unit is ready for
        drive(vq[3]);
        flush = 1'b1;
        #1;
        check("flush_ready_a", 64'(if_a.in_ready), 64'd1);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_a", 64'(if_a.out_valid), 64'd0);

        // Asynchronous reset in the middle of traffic
        out_ready = 1'b0;
        drive(vq[3]);
        @(posedge clk); #1;
        drive(vq[0]);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_c",  64'(if_c.out_valid), 64'd0);
        check("midrst_target_c", if_c.out_target, 64'd0);
        check("midrst_imm_a",    64'(if_a.out_imm), 64'd0);
        check("midrst_tag_a",    64'(if_a.out_tag), 64'd0);
        check("midrst_valid_b",  64'(if_b.out_valid), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(vq[0]);
        #1;
        check("midrst_ready_a", 64'(if_a.in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst_first_valid",  64'(if_a.out_valid), 64'd1);
        check("midrst_first_target", 64'(if_a.out_target), 64'h1234_5000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
